// File: rtl/pool_stage.sv
// Row pooling stage: per-lane bypass, signed max, or rounded average over 1/2/4-row windows.
// One registered output row per completed window, 1 cycle after the completing row.
module pool_stage #(
  parameter int DESIGN_SIZE = 32,
  parameter int DWIDTH      = 8,
  parameter int MASK_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_pool,
  input  logic [1:0]                    pool_mode,
  input  logic [1:0]                    pool_window,
  input  logic [7:0]                    num_rows,
  input  logic                          in_data_available,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
  input  logic [MASK_WIDTH-1:0]         validity_mask,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic                          out_data_available,
  output logic                          done_pool
);

  localparam int AW = DWIDTH + 2;
  localparam int MW = DWIDTH + 3;
  localparam int RW = DESIGN_SIZE * DWIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   is_max_q, is_max_d;
  logic [1:0]             shift_q, shift_d;
  logic [7:0]             num_rows_q, num_rows_d;
  logic [MASK_WIDTH-1:0]  mask_q, mask_d;
  logic [7:0]             row_cnt_q, row_cnt_d;
  logic [2:0]             win_cnt_q, win_cnt_d;
  logic signed [AW-1:0]   acc_q [DESIGN_SIZE];
  logic signed [AW-1:0]   acc_d [DESIGN_SIZE];
  logic signed [AW-1:0]   acc_new [DESIGN_SIZE];
  logic [RW-1:0]          out_q, out_d;
  logic                   out_vld_q, out_vld_d;
  logic [RW-1:0]          pooled;

  logic       accept;
  logic       win_full;
  logic       last_row;
  logic       complete;
  logic [2:0] win_len;

  // Bypass is folded into "average over a 1-row window", which is the identity.
  assign win_len  = 3'd1 << shift_q;
  assign accept   = (state_q == ACCUM) && enable_pool && in_data_available;
  assign win_full = (win_cnt_q + 3'd1) == win_len;
  assign last_row = (row_cnt_q + 8'd1) == num_rows_q;
  assign complete = accept && (win_full || last_row);

  for (genvar i = 0; i < DESIGN_SIZE; i++) begin : g_lane
    logic signed [DWIDTH-1:0] x;
    logic signed [AW-1:0]     x_ext;
    logic                     first;
    logic [MW-1:0]            s_ext;
    logic [MW-1:0]            mag;
    logic [MW-1:0]            half;
    logic [MW-1:0]            rnd;
    logic [MW-1:0]            neg_rnd;
    logic [DWIDTH-1:0]        avg;
    logic [DWIDTH-1:0]        res;
    logic                     lane_vld;

    assign x     = inp_data[i*DWIDTH +: DWIDTH];
    assign x_ext = {{2{x[DWIDTH-1]}}, x};
    assign first = (win_cnt_q == 3'd0);

    always_comb begin
      acc_new[i] = x_ext;
      if (!first) begin
        if (is_max_q) begin
          acc_new[i] = (x_ext > acc_q[i]) ? x_ext : acc_q[i];
        end else begin
          acc_new[i] = acc_q[i] + x_ext;
        end
      end
    end

    // Round half away from zero: round the magnitude, then restore the sign.
    assign s_ext   = {{(MW-AW){acc_new[i][AW-1]}}, acc_new[i]};
    assign mag     = s_ext[MW-1] ? (~s_ext + MW'(1)) : s_ext;
    assign half    = (shift_q == 2'd0) ? '0 : (MW'(1) << (shift_q - 2'd1));
    assign rnd     = (mag + half) >> shift_q;
    assign neg_rnd = ~rnd + MW'(1);
    assign avg     = s_ext[MW-1] ? neg_rnd[DWIDTH-1:0] : rnd[DWIDTH-1:0];
    assign res     = is_max_q ? acc_new[i][DWIDTH-1:0] : avg;

    if (i < MASK_WIDTH) begin : g_mask
      assign lane_vld = mask_q[i];
    end else begin : g_nomask
      assign lane_vld = 1'b1;
    end

    assign pooled[i*DWIDTH +: DWIDTH] = lane_vld ? res : '0;
  end

  always_comb begin
    state_d    = state_q;
    is_max_d   = is_max_q;
    shift_d    = shift_q;
    num_rows_d = num_rows_q;
    mask_d     = mask_q;
    row_cnt_d  = row_cnt_q;
    win_cnt_d  = win_cnt_q;
    acc_d      = acc_q;
    out_d      = out_q;
    out_vld_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_pool) begin
          if (num_rows == 8'd0) begin
            state_d = DONE;
          end else begin
            state_d    = ACCUM;
            is_max_d   = (pool_mode == 2'b01);
            num_rows_d = num_rows;
            mask_d     = validity_mask;
            row_cnt_d  = '0;
            win_cnt_d  = '0;
            if (pool_mode == 2'b01 || pool_mode == 2'b10) begin
              case (pool_window)
                2'b00:   shift_d = 2'd0;
                2'b01:   shift_d = 2'd1;
                default: shift_d = 2'd2;
              endcase
            end else begin
              shift_d = 2'd0;
            end
          end
        end
      end

      ACCUM: begin
        if (!enable_pool) begin
          state_d   = IDLE;
          row_cnt_d = '0;
          win_cnt_d = '0;
          for (int i = 0; i < DESIGN_SIZE; i++) acc_d[i] = '0;
        end else if (accept) begin
          row_cnt_d = row_cnt_q + 8'd1;
          if (complete) begin
            win_cnt_d = '0;
            out_d     = pooled;
            out_vld_d = 1'b1;
            for (int i = 0; i < DESIGN_SIZE; i++) acc_d[i] = '0;
            if (last_row) state_d = DONE;
          end else begin
            win_cnt_d = win_cnt_q + 3'd1;
            acc_d     = acc_new;
          end
        end
      end

      DONE: begin
        if (!enable_pool) begin
          state_d   = IDLE;
          row_cnt_d = '0;
          win_cnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      is_max_q   <= 1'b0;
      shift_q    <= '0;
      num_rows_q <= '0;
      mask_q     <= '0;
      row_cnt_q  <= '0;
      win_cnt_q  <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      for (int i = 0; i < DESIGN_SIZE; i++) acc_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      is_max_q   <= is_max_d;
      shift_q    <= shift_d;
      num_rows_q <= num_rows_d;
      mask_q     <= mask_d;
      row_cnt_q  <= row_cnt_d;
      win_cnt_q  <= win_cnt_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      acc_q      <= acc_d;
    end
  end

  assign out_data           = out_q;
  assign out_data_available = out_vld_q;
  assign done_pool          = (state_q == DONE);

endmodule

// File: tb/tb_pool_stage.sv
// Scoreboard bench for pool_stage: expected rows are queued at stimulus time and
// compared against each out_data_available pulse.
`timescale 1ns/1ps
module tb_pool_stage;
  localparam int DS  = 32;
  localparam int DW  = 8;
  localparam int MKW = 32;
  localparam int W   = DS * DW;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable_pool;
  logic [1:0]     pool_mode;
  logic [1:0]     pool_window;
  logic [7:0]     num_rows;
  logic           in_data_available;
  logic [W-1:0]   inp_data;
  logic [MKW-1:0] validity_mask;
  logic [W-1:0]   out_data;
  logic           out_data_available;
  logic           done_pool;

  pool_stage #(.DESIGN_SIZE(DS), .DWIDTH(DW), .MASK_WIDTH(MKW)) dut (
    .clk               (clk),
    .reset             (reset),
    .enable_pool       (enable_pool),
    .pool_mode         (pool_mode),
    .pool_window       (pool_window),
    .num_rows          (num_rows),
    .in_data_available (in_data_available),
    .inp_data          (inp_data),
    .validity_mask     (validity_mask),
    .out_data          (out_data),
    .out_data_available(out_data_available),
    .done_pool         (done_pool)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  int           n_pulses = 0;
  int           cyc = 0;
  int           first_pulse_cyc = -1;
  int           last_pulse_cyc = -1;
  int           first_row_cyc = -1;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out = '0;
  logic [W-1:0] job_rows[16];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_data_available === 1'b1) begin
      logic [W-1:0] e;
      n_pulses++;
      if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
      last_pulse_cyc = cyc;
      last_out = out_data;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse: out_data=%h but no row expected", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_errors++;
          $display("FAIL scoreboard_row: got %h expected %h", out_data, e);
        end
      end
    end
  end

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int eff_win(int mode, int wcode);
    if (mode == 1 || mode == 2) return (wcode == 0) ? 1 : (wcode == 1) ? 2 : 4;
    return 1;
  endfunction

  function automatic logic [W-1:0] model_win(int mode, int w, int start, int cnt, logic [MKW-1:0] mask);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < DS; l++) begin
      int acc;
      int v;
      int q;
      acc = 0;
      for (int k = 0; k < cnt; k++) begin
        v = int'($signed(job_rows[start+k][l*DW +: DW]));
        if (mode == 1) begin
          if (k == 0 || v > acc) acc = v;
        end else begin
          acc += v;
        end
      end
      if (mode == 1) q = acc;
      else if (acc >= 0) q = (acc + w / 2) / w;
      else q = -((-acc + w / 2) / w);
      if (mask[l]) r[l*DW +: DW] = q[DW-1:0];
    end
    return r;
  endfunction

  task automatic push_expect(int mode, int wcode, int n, logic [MKW-1:0] mask);
    int w;
    w = eff_win(mode, wcode);
    for (int s = 0; s < n; s += w)
      exp_q.push_back(model_win(mode, w, s, (n - s < w) ? n - s : w, mask));
  endtask

  task automatic start_job(int mode, int wcode, int n, logic [MKW-1:0] mask, logic garbage);
    pool_mode         = 2'(mode);
    pool_window       = 2'(wcode);
    num_rows          = 8'(n);
    validity_mask     = mask;
    enable_pool       = 1'b1;
    n_pulses          = 0;
    first_pulse_cyc   = -1;
    in_data_available = garbage;
    inp_data          = rand_row();
    @(posedge clk); #1;
    in_data_available = 1'b0;
  endtask

  task automatic drive_rows(int n, bit gaps);
    for (int r = 0; r < n; r++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_data_available = 1'b0;
        inp_data = rand_row();
        @(posedge clk); #1;
      end
      in_data_available = 1'b1;
      inp_data = job_rows[r];
      @(posedge clk); #1;
      if (r == 0) first_row_cyc = cyc;
    end
    in_data_available = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_pool !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
  endtask

  task automatic end_job();
    enable_pool = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable_pool = 1'b0; in_data_available = 1'b0;
    pool_mode = 2'b00; pool_window = 2'b00; num_rows = 8'd0;
    inp_data = '0; validity_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_checks++; if (out_data_available !== 1'b0) begin n_errors++; $display("FAIL reset_out_vld: got %b expected 0", out_data_available); end
    n_checks++; if (done_pool !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done_pool); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_avg_round(logic [7:0] a, logic [7:0] b, logic [7:0] want);
    job_rows[0] = rand_row(); job_rows[0][7:0] = a;
    job_rows[1] = rand_row(); job_rows[1][7:0] = b;
    push_expect(2, 1, 2, '1);
    start_job(2, 1, 2, '1, 1'b1);
    drive_rows(2, 1'b0);
    wait_done();
    n_checks++; if (done_pool !== 1'b1) begin n_errors++; $display("FAIL avg_done: got %b expected 1", done_pool); end
    n_checks++; if (n_pulses !== 1) begin n_errors++; $display("FAIL avg_pulses: got %0d expected 1", n_pulses); end
    n_checks++; if (last_out[7:0] !== want) begin n_errors++; $display("FAIL avg_lane0: got %h expected %h", last_out[7:0], want); end
    in_data_available = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_data_available = 1'b0;
    n_checks++; if (n_pulses !== 1 || done_pool !== 1'b1) begin n_errors++; $display("FAIL done_ignores_rows: pulses=%0d done=%b expected 1/1", n_pulses, done_pool); end
    end_job();
    n_checks++; if (done_pool !== 1'b0) begin n_errors++; $display("FAIL done_clear: got %b expected 0", done_pool); end
  endtask

  task automatic test_max_mask();
    logic [7:0] l0 [4];
    l0[0] = 8'hF0; l0[1] = 8'h08; l0[2] = 8'h7F; l0[3] = 8'h80;
    for (int r = 0; r < 4; r++) begin job_rows[r] = rand_row(); job_rows[r][7:0] = l0[r]; end
    push_expect(1, 2, 4, 32'h5555_5555);
    start_job(1, 2, 4, 32'h5555_5555, 1'b0);
    drive_rows(4, 1'b0);
    wait_done();
    n_checks++; if (n_pulses !== 1) begin n_errors++; $display("FAIL max_pulses: got %0d expected 1", n_pulses); end
    n_checks++; if (last_out[7:0] !== 8'h7F) begin n_errors++; $display("FAIL max_lane0: got %h expected 7f", last_out[7:0]); end
    n_checks++; if (last_out[15:8] !== 8'h00) begin n_errors++; $display("FAIL max_masked_lane1: got %h expected 00", last_out[15:8]); end
    end_job();
  endtask

  task automatic test_partial_avg();
    for (int r = 0; r < 3; r++) job_rows[r] = {DS{8'h10}};
    push_expect(2, 1, 3, '1);
    start_job(2, 1, 3, '1, 1'b0);
    pool_mode = 2'b01; pool_window = 2'b00; num_rows = 8'd1; validity_mask = '0;
    drive_rows(3, 1'b0);
    wait_done();
    n_checks++; if (n_pulses !== 2) begin n_errors++; $display("FAIL partial_pulses: got %0d expected 2", n_pulses); end
    n_checks++; if (last_out[7:0] !== 8'h08) begin n_errors++; $display("FAIL partial_lane0: got %h expected 08", last_out[7:0]); end
    n_checks++; if (done_pool !== 1'b1) begin n_errors++; $display("FAIL partial_done: got %b expected 1", done_pool); end
    end_job();
  endtask

  task automatic test_back_to_back();
    logic [MKW-1:0] m;
    m = $urandom | 32'h1;
    for (int r = 0; r < 4; r++) job_rows[r] = rand_row();
    push_expect(0, 2, 4, m);
    start_job(0, 2, 4, m, 1'b0);
    drive_rows(4, 1'b0);
    wait_done();
    n_checks++; if (n_pulses !== 4) begin n_errors++; $display("FAIL b2b_pulses: got %0d expected 4", n_pulses); end
    n_checks++; if (last_pulse_cyc - first_pulse_cyc !== 3) begin n_errors++; $display("FAIL b2b_spacing: got span %0d expected 3", last_pulse_cyc - first_pulse_cyc); end
    n_checks++; if (first_pulse_cyc !== first_row_cyc) begin n_errors++; $display("FAIL b2b_latency: pulse cycle %0d expected %0d", first_pulse_cyc, first_row_cyc); end
    end_job();
  endtask

  task automatic test_abort();
    for (int r = 0; r < 4; r++) job_rows[r] = rand_row();
    start_job(2, 2, 4, '1, 1'b0);
    drive_rows(2, 1'b0);
    end_job();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (n_pulses !== 0 || done_pool !== 1'b0) begin n_errors++; $display("FAIL abort_quiet: pulses=%0d done=%b expected 0/0", n_pulses, done_pool); end
    for (int r = 0; r < 2; r++) job_rows[r] = rand_row();
    push_expect(2, 1, 2, '1);
    start_job(2, 1, 2, '1, 1'b0);
    drive_rows(2, 1'b0);
    wait_done();
    n_checks++; if (n_pulses !== 1 || exp_q.size() !== 0) begin n_errors++; $display("FAIL abort_restart: pulses=%0d pending=%0d expected 1/0", n_pulses, exp_q.size()); end
    end_job();
  endtask

  task automatic test_zero_rows();
    start_job(1, 1, 0, '1, 1'b1);
    n_checks++; if (done_pool !== 1'b1) begin n_errors++; $display("FAIL zero_rows_done: got %b expected 1", done_pool); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (n_pulses !== 0) begin n_errors++; $display("FAIL zero_rows_pulse: got %0d expected 0", n_pulses); end
    end_job();
  endtask

  task automatic test_reset_mid();
    job_rows[0] = {DS{8'h40}};
    start_job(2, 1, 2, '1, 1'b0);
    drive_rows(1, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_data !== '0 || out_data_available !== 1'b0 || done_pool !== 1'b0) begin
      n_errors++; $display("FAIL midreset_outputs: out=%h vld=%b done=%b expected all 0", out_data, out_data_available, done_pool);
    end
    reset = 1'b0;
    job_rows[0] = {DS{8'h02}};
    job_rows[1] = {DS{8'h04}};
    push_expect(2, 1, 2, '1);
    n_pulses = 0;
    @(posedge clk); #1;
    drive_rows(2, 1'b0);
    wait_done();
    n_checks++; if (n_pulses !== 1) begin n_errors++; $display("FAIL midreset_pulses: got %0d expected 1", n_pulses); end
    n_checks++; if (last_out[7:0] !== 8'h03) begin n_errors++; $display("FAIL midreset_lane0: got %h expected 03", last_out[7:0]); end
    end_job();
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      int mode;
      int wc;
      int n;
      int w;
      logic [MKW-1:0] m;
      mode = $urandom_range(0, 3);
      wc   = $urandom_range(0, 3);
      n    = $urandom_range(1, 12);
      m    = $urandom;
      w    = eff_win(mode, wc);
      for (int r = 0; r < n; r++) job_rows[r] = rand_row();
      push_expect(mode, wc, n, m);
      start_job(mode, wc, n, m, 1'b1);
      drive_rows(n, 1'b1);
      wait_done();
      n_checks++; if (n_pulses !== (n + w - 1) / w || exp_q.size() !== 0) begin
        n_errors++; $display("FAIL random_job%0d: pulses=%0d pending=%0d expected %0d/0", j, n_pulses, exp_q.size(), (n + w - 1) / w);
      end
      end_job();
    end
  endtask

  initial begin
    test_reset();
    test_avg_round(8'h0C, 8'h05, 8'h09);
    test_avg_round(8'hF4, 8'hFB, 8'hF7);
    test_max_mask();
    test_partial_avg();
    test_back_to_back();
    test_abort();
    test_zero_rows();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pool_stage.md
POOL_STAGE -- requirements
Module: pool_stage

Interface
REQ-001 SHALL have parameters: DESIGN_SIZE, default 32, lanes per row; DWIDTH, default 8, bits per lane (signed Q5.3); MASK_WIDTH, default 32, validity mask width.
REQ-002 SHALL have ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- enable_pool  input  1  stage enable; deassertion aborts and returns to idle.
- pool_mode  input  2  00 bypass, 01 max, 10 average, 11 treated as bypass.
- pool_window  input  2  00 = 1 row, 01 = 2 rows, 10 = 4 rows, 11 treated as 4.
- num_rows  input  8  total input rows in this job.
- in_data_available  input  1  inp_data valid this cycle (upstream norm output).
- inp_data  input  DESIGN_SIZE*DWIDTH  row; lane i at [i*DWIDTH +: DWIDTH].
- validity_mask  input  MASK_WIDTH  bit i = 1 means lane i valid.
- out_data  output  DESIGN_SIZE*DWIDTH  pooled row, registered.
- out_data_available  output  1  one-cycle pulse per pooled row.
- done_pool  output  1  job complete, level.

Function
REQ-003 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-004 IDLE -> ACCUM when enable_pool = 1 and num_rows != 0; IDLE -> DONE when enable_pool = 1 and num_rows = 0, with no output pulse.
REQ-005 SHALL sample pool_mode, pool_window, num_rows and validity_mask on the IDLE -> ACCUM transition; later changes are ignored until the next job.
REQ-006 In ACCUM, each cycle with in_data_available = 1 SHALL accept one row; the row counter and the window counter each increment.
REQ-007 Window completion: the window counter reaches the programmed window, or the row counter reaches num_rows. Completion SHALL register out_data and pulse out_data_available on the next rising edge (latency 1 cycle from the completing row).
REQ-008 Completion SHALL clear the accumulators so the row accepted on the following cycle starts a new window; back-to-back windows with no idle cycle SHALL be supported.
REQ-009 Bypass: every accepted row SHALL produce an output 1 cycle later; window ignored.
REQ-010 Max: per-lane signed maximum over the rows in the window.
REQ-011 Average: per-lane signed sum in DWIDTH+2 bits, arithmetic right shift by log2(window).
- Rounding: round half away from zero; a shifted-out fraction >= 0.5 increments magnitude.
- Window 1 SHALL be identity.
REQ-012 Partial final window (num_rows not a multiple of window):
- Max SHALL use only the received rows.
- Average SHALL divide by the programmed window (zero padding).
REQ-013 Lanes with a sampled mask bit of 0 SHALL output 0x00 in all modes.
REQ-014 After the completion that consumes row num_rows, SHALL enter DONE.
- done_pool = 1 while in DONE.
- in_data_available is ignored in DONE.
- DONE -> IDLE when enable_pool = 0.
REQ-015 enable_pool = 0 in ACCUM SHALL return to IDLE next cycle and discard partial accumulators; no output pulse.
REQ-016 in_data_available in IDLE SHALL be ignored, including in the cycle enable_pool rises; the first row is accepted in ACCUM.

Reset
REQ-017 reset = 1 SHALL, on the next rising edge, set:
- state IDLE;
- out_data = 0, out_data_available = 0, done_pool = 0;
- all counters and accumulators = 0.
REQ-018 Reset SHALL override all other inputs, including mid-window and in DONE.

Verification
REQ-019 Avg, window 2, num_rows 2; lane0 rows 0x0C then 0x05 -> out lane0 = 0x09 (8.5 rounded away from zero), single pulse, done_pool next cycle.
REQ-020 Avg, window 2; lane0 rows 0xF4 then 0xFB -> out lane0 = 0xF7 (-8.5 rounded to -9).
REQ-021 Max, window 4, num_rows 4; lane0 rows 0xF0, 0x08, 0x7F, 0x80 -> out lane0 = 0x7F; lanes with mask bit 0 -> 0x00.
REQ-022 Avg, window 2, num_rows 3; all lanes 0x10 on three consecutive cycles -> two pulses, 0x10 then 0x08 (partial window), then done_pool = 1.
REQ-023 Bypass, num_rows 4, rows back-to-back -> four consecutive out_data_available pulses, each equal to its masked input row delayed by 1 cycle.
REQ-024 reset asserted after 1 of 2 window rows; restart job -> no stale data; first output uses only post-reset rows; all outputs 0 during reset.
